// File: rtl/overlay_fetch_if.sv
// Memory read port of the overlay prefetcher: request/ack plus in-order return.
// Latency: none (wires only).
// Backpressure: a request is held until acked; returns are never stalled.
interface overlay_fetch_if #(
    parameter int ADDR_WIDTH  = 24,
    parameter int PIXEL_WIDTH = 8
);
    logic                     mem_req;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic                     mem_ack;
    logic                     mem_rvalid;
    logic [4*PIXEL_WIDTH-1:0] mem_rdata;

    // Fetch engine side: issues requests, receives returns.
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rvalid,
        input  mem_rdata
    );

    // Memory side: accepts requests, produces returns.
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/overlay_fetch.sv
// Prefetches packed RGBA overlay pixels into a small show-ahead FIFO for the blender.
// Latency: a return written into an empty FIFO appears on overlay* one cycle later.
// Backpressure: requests issue only while FIFO occupancy plus in-flight reads fit the FIFO.
module overlay_fetch #(
    parameter int PIXEL_WIDTH = 8,
    parameter int ADDR_WIDTH  = 24,
    parameter int CNT_WIDTH   = 22,
    parameter int FIFO_AW     = 3
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   i_enable,
    input  logic [ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [CNT_WIDTH-1:0]   i_num_pixels,
    overlay_fetch_if.master        mem,
    input  logic                   i_overlay_adv,
    input  logic                   i_overlay_restart,
    output logic [PIXEL_WIDTH-1:0] o_overlay0,
    output logic [PIXEL_WIDTH-1:0] o_overlay1,
    output logic [PIXEL_WIDTH-1:0] o_overlay2,
    output logic [PIXEL_WIDTH-1:0] o_overlayA,
    output logic [15:0]            o_underflow_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;     // holds 0..DEPTH
    localparam int DW    = 4 * PIXEL_WIDTH;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    // S_STALE: a request raised before a restart is still waiting for its ack;
    // its data will be dropped and the address reloads once it is accepted.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_STALE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_mem_req;

    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [CNT_WIDTH-1:0]   r_fetched;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [CNT_WIDTH-1:0]   r_num;
    logic                   r_enable_d;
    logic [CW-1:0]          r_outstanding;
    logic [CW-1:0]          r_drop;
    logic [CW-1:0]          r_count;
    logic [FIFO_AW-1:0]     r_wr_ptr;
    logic [FIFO_AW-1:0]     r_rd_ptr;
    logic [DW-1:0]          r_mem [DEPTH];
    logic [DW-1:0]          r_head;
    logic [15:0]            r_underflow_cnt;

    logic                   w_fire;
    logic                   w_flush;
    logic                   w_sample;
    logic                   w_hold_req;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_underflow;
    logic                   w_can_req;
    logic [CW-1:0]          w_count_nxt;
    logic [CW-1:0]          w_outstanding_nxt;
    logic [CW-1:0]          w_drop_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr_nxt;
    logic [CNT_WIDTH-1:0]   w_fetched_nxt;
    logic [ADDR_WIDTH-1:0]  w_base_nxt;
    logic [CNT_WIDTH-1:0]   w_num_nxt;
    logic [FIFO_AW-1:0]     w_rd_ptr_inc;
    logic [DW-1:0]          w_head_nxt;

    assign w_fire     = w_mem_req && mem.mem_ack;
    assign w_flush    = !i_enable || i_overlay_restart;
    // Frame parameters are captured only at a restart or at the enable rising edge.
    assign w_sample   = i_enable && (i_overlay_restart || !r_enable_d);
    assign w_hold_req = w_mem_req && !mem.mem_ack;

    // FIFO traffic, in-flight accounting and discard bookkeeping for this edge.
    always_comb begin
        w_push            = mem.mem_rvalid && !w_flush && (r_drop == '0);
        w_pop             = i_overlay_adv && i_enable && !i_overlay_restart && (r_count != '0);
        w_underflow       = i_overlay_adv && i_enable && !i_overlay_restart && (r_count == '0);
        w_outstanding_nxt = r_outstanding + CW'(w_fire) - CW'(mem.mem_rvalid);
        w_count_nxt       = w_flush ? '0 : (r_count + CW'(w_push) - CW'(w_pop));
        if (w_flush) begin
            // Everything still in flight belongs to the old frame.
            w_drop_nxt = w_outstanding_nxt;
        end else begin
            w_drop_nxt = r_drop
                       - CW'(mem.mem_rvalid && (r_drop != '0))
                       + CW'(w_fire && (r_state == S_STALE));
        end
    end

    // Next fetch address, fetch count and sampled frame parameters.
    always_comb begin
        w_addr_nxt    = r_mem_addr;
        w_fetched_nxt = r_fetched;
        w_base_nxt    = r_base;
        w_num_nxt     = r_num;
        if (!i_enable) begin
            w_addr_nxt    = i_base_addr;
            w_fetched_nxt = '0;
        end else if (w_sample) begin
            w_base_nxt = i_base_addr;
            w_num_nxt  = i_num_pixels;
            // A pending unacked request keeps its address until accepted.
            if (!w_hold_req) begin
                w_addr_nxt    = i_base_addr;
                w_fetched_nxt = '0;
            end
        end else if (w_fire && (r_state == S_STALE)) begin
            w_addr_nxt    = r_base;
            w_fetched_nxt = '0;
        end else if (w_fire) begin
            w_addr_nxt    = r_mem_addr + ADDR_WIDTH'(1);
            w_fetched_nxt = r_fetched + CNT_WIDTH'(1);
        end
    end

    // Credit check: issue only if the read would still fit in the FIFO.
    always_comb begin
        w_can_req = i_enable
                 && (w_fetched_nxt < w_num_nxt)
                 && (({1'b0, w_count_nxt} + {1'b0, w_outstanding_nxt}) < DEPTH_LIM);
    end

    // Request FSM: state register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Request FSM: next state; a raised request holds until acked unless disabled.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_can_req ? S_REQ : S_IDLE;
            S_REQ: begin
                if (mem.mem_ack)            w_state_nxt = w_can_req ? S_REQ : S_IDLE;
                else if (i_overlay_restart) w_state_nxt = S_STALE;
                else                        w_state_nxt = S_REQ;
            end
            S_STALE: begin
                if (mem.mem_ack) w_state_nxt = w_can_req ? S_REQ : S_IDLE;
                else             w_state_nxt = S_STALE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (!i_enable) w_state_nxt = S_IDLE;
    end

    // Request FSM: outputs.
    always_comb begin
        w_mem_req = (r_state != S_IDLE);
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = r_mem_addr;

    // Fetch pointer, frame parameters and in-flight counters.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_mem_addr    <= '0;
            r_fetched     <= '0;
            r_base        <= '0;
            r_num         <= '0;
            r_enable_d    <= 1'b0;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_mem_addr    <= w_addr_nxt;
            r_fetched     <= w_fetched_nxt;
            r_base        <= w_base_nxt;
            r_num         <= w_num_nxt;
            r_enable_d    <= i_enable;
            r_outstanding <= w_outstanding_nxt;
            r_drop        <= w_drop_nxt;
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= mem.mem_rdata;
    end

    // FIFO pointers and occupancy; a flush simply rewinds both pointers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            r_count <= w_count_nxt;
        end
    end

    assign w_rd_ptr_inc = r_rd_ptr + FIFO_AW'(1);

    // Next show-ahead head: zero when the FIFO will be empty, else the oldest entry.
    always_comb begin
        w_head_nxt = r_head;
        if (w_flush) begin
            w_head_nxt = '0;
        end else if (r_count == '0) begin
            w_head_nxt = w_push ? mem.mem_rdata : '0;
        end else if (w_pop) begin
            if (r_count == CW'(1)) w_head_nxt = w_push ? mem.mem_rdata : '0;
            else                   w_head_nxt = r_mem[w_rd_ptr_inc];
        end
    end

    // Registered head so the blender sees flop outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_head <= '0;
        else         r_head <= w_head_nxt;
    end

    // Saturating count of advances that found no pixel ready.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)                                         r_underflow_cnt <= '0;
        else if (w_underflow && (r_underflow_cnt != 16'hFFFF)) r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end

    assign o_overlay0      = r_head[PIXEL_WIDTH-1:0];
    assign o_overlay1      = r_head[2*PIXEL_WIDTH-1:PIXEL_WIDTH];
    assign o_overlay2      = r_head[3*PIXEL_WIDTH-1:2*PIXEL_WIDTH];
    assign o_overlayA      = r_head[4*PIXEL_WIDTH-1:3*PIXEL_WIDTH];
    assign o_underflow_cnt = r_underflow_cnt;

endmodule

// File: tb/tb_overlay_fetch.sv
// Bench for overlay_fetch: random memory latency/acks against a transaction-level model.
// Latency: model state advances once per clock edge, outputs compared on the falling edge.
// Backpressure: memory ack pattern and return latency are chosen per phase.
module tb_overlay_fetch;
    localparam int PW = 8;
    localparam int AW = 24;
    localparam int CW = 22;

    logic          clk = 1'b0;
    logic          resetb;
    logic          i_enable;
    logic [AW-1:0] i_base_addr;
    logic [CW-1:0] i_num_pixels;
    logic          i_overlay_adv;
    logic          i_overlay_restart;
    logic [PW-1:0] o_overlay0, o_overlay1, o_overlay2, o_overlayA;
    logic [15:0]   o_underflow_cnt;

    overlay_fetch_if #(.ADDR_WIDTH(AW), .PIXEL_WIDTH(PW)) mif ();

    overlay_fetch #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .FIFO_AW(3)) dut (
        .clk               (clk),
        .resetb            (resetb),
        .i_enable          (i_enable),
        .i_base_addr       (i_base_addr),
        .i_num_pixels      (i_num_pixels),
        .mem               (mif),
        .i_overlay_adv     (i_overlay_adv),
        .i_overlay_restart (i_overlay_restart),
        .o_overlay0        (o_overlay0),
        .o_overlay1        (o_overlay1),
        .o_overlay2        (o_overlay2),
        .o_overlayA        (o_overlayA),
        .o_underflow_cnt   (o_underflow_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory content: each word is a fixed function of its address.
    function automatic logic [31:0] pix(input logic [AW-1:0] a);
        return {a[7:0] | 8'h01, a[7:0] ^ a[15:8], a[23:16] ^ 8'h5A, a[7:0]};
    endfunction

    // Memory environment: returns in order after a per-phase latency.
    typedef struct { logic [31:0] dat; int due; } mret_t;
    mret_t mq[$];
    int    cyc      = 0;
    int    last_due = 0;
    int    lat_min  = 2;
    int    lat_max  = 2;
    int    ack_mode = 0;   // 0 always ack, 1 random, 2 never
    int    n_fire   = 0;

    // Reference model: transactions tagged fresh/stale, FIFO as a queue of pixels.
    typedef struct { bit fresh; logic [31:0] pix; } infl_t;
    infl_t       m_infl[$];
    logic [31:0] m_fifo[$];
    bit          m_en_d  = 0;
    bit          m_req   = 0;
    bit          m_stale = 0;
    logic [AW-1:0] m_addr = '0;
    logic [AW-1:0] m_base = '0;
    int          m_fetched = 0;
    int          m_num     = 0;
    int          m_uf      = 0;

    task automatic model_update(input bit en, input bit rst, input bit adv, input bit ack, input bit rv);
        bit    fire, hold, rise;
        infl_t e;
        fire = m_req && ack;
        hold = m_req && !ack;
        if (rv && m_infl.size() > 0) begin
            e = m_infl[0];
            m_infl.delete(0);
        end else begin
            e = '{fresh: 1'b0, pix: 32'h0};
        end
        if (!en) begin
            foreach (m_infl[i]) m_infl[i].fresh = 1'b0;
            if (fire) m_infl.push_back('{fresh: 1'b0, pix: pix(m_addr)});
            m_fifo.delete();
            m_req = 0; m_stale = 0; m_en_d = 0; m_fetched = 0;
            return;
        end
        rise   = !m_en_d;
        m_en_d = 1;
        if (adv && !rst) begin
            if (m_fifo.size() > 0) m_fifo.delete(0);
            else if (m_uf < 65535) m_uf++;
        end
        if (rv && e.fresh && !rst) m_fifo.push_back(e.pix);
        if (rst) m_fifo.delete();
        if (fire) begin
            m_infl.push_back('{fresh: !m_stale && !rst, pix: pix(m_addr)});
            if (m_stale) begin
                m_addr = m_base; m_fetched = 0; m_stale = 0;
            end else begin
                m_addr = m_addr + 1'b1; m_fetched++;
            end
        end
        if (rst || rise) begin
            m_base = i_base_addr;
            m_num  = int'(i_num_pixels);
            if (hold) m_stale = 1;
            else begin m_addr = m_base; m_fetched = 0; end
        end
        if (rst) foreach (m_infl[i]) m_infl[i].fresh = 1'b0;
        m_req = hold ? 1'b1 : ((m_fetched < m_num) && (m_fifo.size() + m_infl.size() < 8));
    endtask

    task automatic check_outputs();
        logic [31:0] exp_head;
        exp_head = (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
        chk("mem_req", mif.mem_req, m_req);
        if (m_req) chk("mem_addr", mif.mem_addr, m_addr);
        chk("overlay_head", {o_overlayA, o_overlay2, o_overlay1, o_overlay0}, exp_head);
        chk("underflow_cnt", o_underflow_cnt, m_uf);
    endtask

    // One clock: drive inputs at the falling edge, advance the model, check next falling edge.
    task automatic step(input bit en, input bit rst, input bit adv);
        bit          ack, rv;
        logic [31:0] rd;
        int          due;
        case (ack_mode)
            0:       ack = 1'b1;
            1:       ack = ($urandom_range(0, 1) == 1);
            default: ack = 1'b0;
        endcase
        rv = 1'b0;
        rd = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rv = 1'b1;
            rd = mq[0].dat;
            mq.delete(0);
        end
        if (mif.mem_req && ack) begin
            due = cyc + int'($urandom_range(lat_min, lat_max));
            if (due < last_due) due = last_due;
            last_due = due;
            mq.push_back('{dat: pix(mif.mem_addr), due: due});
            n_fire++;
        end
        i_enable          = en;
        i_overlay_restart = rst;
        i_overlay_adv     = adv;
        mif.mem_ack       = ack;
        mif.mem_rvalid    = rv;
        mif.mem_rdata     = rd;
        model_update(en, rst, adv, ack, rv);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        int f0;
        int u0;
        resetb            = 1'b0;
        i_enable          = 1'b0;
        i_base_addr       = '0;
        i_num_pixels      = '0;
        i_overlay_adv     = 1'b0;
        i_overlay_restart = 1'b0;
        mif.mem_ack       = 1'b0;
        mif.mem_rvalid    = 1'b0;
        mif.mem_rdata     = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_addr", mif.mem_addr, 0);
        check_outputs();
        resetb = 1'b1;

        // Short frame, same-cycle ack, two-cycle return.
        ack_mode = 0; lat_min = 2; lat_max = 2;
        i_base_addr = 24'h000100; i_num_pixels = 4;
        f0 = n_fire;
        step(1, 0, 0);
        repeat (3) step(1, 0, 0);
        chk("t1_first_head", {o_overlayA, o_overlay2, o_overlay1, o_overlay0}, pix(24'h000100));
        repeat (8) step(1, 0, 0);
        chk("t1_req_count", n_fire - f0, 4);
        repeat (6) step(1, 0, 1);

        // Long frame without consumption: credit limit stops at the FIFO depth.
        i_base_addr = 24'h002000; i_num_pixels = 20;
        f0 = n_fire;
        step(1, 1, 0);
        repeat (24) step(1, 0, 0);
        chk("t2_burst", n_fire - f0, 8);
        chk("t2_req_idle", mif.mem_req, 0);
        step(1, 0, 1);
        repeat (5) step(1, 0, 0);
        chk("t2_one_more", n_fire - f0, 9);

        // Underflow on an empty frame.
        i_num_pixels = 0;
        step(0, 0, 0);
        step(1, 0, 0);
        u0 = m_uf;
        repeat (3) step(1, 0, 1);
        step(1, 0, 0);
        chk("t3_underflow", o_underflow_cnt, u0 + 3);
        chk("t3_alpha_zero", o_overlayA, 0);

        // Restart with three in flight and one unacked request.
        lat_min = 6; lat_max = 6;
        i_base_addr = 24'h004000; i_num_pixels = 20;
        step(0, 0, 0);
        repeat (8) step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(1, 0, 0);
        ack_mode = 2;
        i_base_addr = 24'h005000;
        step(1, 1, 0);
        chk("t4_flushed", o_overlayA, 0);
        step(1, 0, 0);
        ack_mode = 0;
        repeat (20) step(1, 0, 0);
        chk("t4_head", {o_overlayA, o_overlay2, o_overlay1, o_overlay0}, pix(24'h005000));

        // Restart and advance together with five pixels buffered.
        lat_min = 2; lat_max = 2;
        i_base_addr = 24'h006000; i_num_pixels = 5;
        step(1, 1, 0);
        repeat (15) step(1, 0, 0);
        chk("t5_prefill", {o_overlayA, o_overlay2, o_overlay1, o_overlay0}, pix(24'h006000));
        u0 = m_uf;
        i_base_addr = 24'h007000; i_num_pixels = 3;
        step(1, 1, 1);
        chk("t5_empty", {o_overlayA, o_overlay2, o_overlay1, o_overlay0}, 0);
        chk("t5_uf_same", o_underflow_cnt, u0);
        repeat (10) step(1, 0, 0);
        chk("t5_head", {o_overlayA, o_overlay2, o_overlay1, o_overlay0}, pix(24'h007000));

        // Enable dropped mid-burst, then re-raised on a new base.
        lat_min = 3; lat_max = 3;
        i_base_addr = 24'h008000; i_num_pixels = 20;
        step(1, 1, 0);
        repeat (4) step(1, 0, 0);
        step(0, 0, 0);
        chk("t6_req_low", mif.mem_req, 0);
        i_base_addr = 24'h009000;
        step(0, 0, 0);
        repeat (16) step(1, 0, 0);
        chk("t6_head", {o_overlayA, o_overlay2, o_overlay1, o_overlay0}, pix(24'h009000));

        // Random traffic, including address wrap near the top of memory.
        ack_mode = 1; lat_min = 2; lat_max = 5;
        for (int i = 0; i < 400; i++) begin
            bit en, rst, adv;
            en  = ($urandom_range(0, 15) != 0);
            rst = ($urandom_range(0, 24) == 0);
            adv = ($urandom_range(0, 2) != 0);
            if (rst || !en) begin
                i_base_addr  = ($urandom_range(0, 3) == 0) ? 24'hFFFFFC : AW'($urandom);
                i_num_pixels = CW'($urandom_range(0, 12));
            end
            step(en, rst, adv);
        end

        // Underflow counter saturation.
        ack_mode = 0;
        i_base_addr = '0; i_num_pixels = 0;
        step(1, 1, 0);
        for (int i = 0; i < 65540; i++) step(1, 0, 1);
        chk("t3_saturate", o_underflow_cnt, 16'hFFFF);
        repeat (3) step(1, 0, 1);
        chk("t3_stay_sat", o_underflow_cnt, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
